// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state and flag bundle for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_PASS = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ov;
  } flags_t;

  localparam flags_t FLAGS_CLR = 4'b0000;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the execute stage and the multi-cycle ALU.
interface alu_mc_if #(
  parameter int WIDTH = 64
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zeroflag;
  logic             negflag;
  logic             carryflag;
  logic             ovflag;
  logic             busy;

  modport master (
    output in_valid, mode, A, B, out_ready,
    input  in_ready, out_valid, out, zeroflag, negflag, carryflag, ovflag, busy
  );

  modport slave (
    input  in_valid, mode, A, B, out_ready,
    output in_ready, out_valid, out, zeroflag, negflag, carryflag, ovflag, busy
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, LSB of b first.
// done and p are valid in the cycle of the final step so the caller can register them.
module alu_mul_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mc_r;
  logic [WIDTH-1:0] mp_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             active_r;
  logic [WIDTH-1:0] acc_next_s;

  // Accumulate the current partial product.
  always_comb begin
    acc_next_s = acc_r;
    if (mp_r[0]) begin
      acc_next_s = acc_r + mc_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  assign done = active_r && (cnt_r == CW'(WIDTH - 1));
  assign p    = acc_next_s;

  // Operand load on start, then one step per cycle until the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mc_r     <= {WIDTH{1'b0}};
      mp_r     <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      active_r <= 1'b0;
    end else if (start) begin
      mc_r     <= a;
      mp_r     <= b;
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      active_r <= 1'b1;
    end else if (active_r) begin
      acc_r <= acc_next_s;
      mc_r  <= mc_r << 1;
      mp_r  <= mp_r >> 1;
      cnt_r <= cnt_r + CW'(1);
      if (done) begin
        active_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops plus an optional
// sequential multiply, valid/ready on both sides, registered result and flags.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int MUL_EN = 1
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_r;
  logic [WIDTH-1:0] out_r;
  flags_t           flags_r;
  logic             out_valid_r;
  logic             busy_r;

  logic             accept_s;
  logic             pop_s;
  logic             is_mul_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_p_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             ov_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [SHW-1:0]   sh_s;

  function automatic flags_t mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    flags_t f;
    f.zero  = (r == {WIDTH{1'b0}});
    f.neg   = r[WIDTH-1];
    f.carry = c;
    f.ov    = v;
    return f;
  endfunction

  assign bus.in_ready = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign pop_s        = out_valid_r && bus.out_ready;
  assign is_mul_s     = (MUL_EN != 0) && (bus.mode == ALU_MUL);

  // Single-cycle operation mux; mul and unused opcodes fall through to zero.
  always_comb begin
    sh_s    = bus.B[SHW-1:0];
    sum_s   = {1'b0, bus.A} + {1'b0, bus.B};
    diff_s  = {1'b0, bus.A} - {1'b0, bus.B};
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ov_s    = 1'b0;
    case (bus.mode)
      ALU_AND:  res_s = bus.A & bus.B;
      ALU_OR:   res_s = bus.A | bus.B;
      ALU_ADD: begin
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ov_s    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      ALU_SUB: begin
        res_s   = diff_s[WIDTH-1:0];
        carry_s = diff_s[WIDTH];
        ov_s    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      ALU_PASS: res_s = bus.B;
      ALU_XOR:  res_s = bus.A ^ bus.B;
      ALU_SLL:  res_s = bus.A << sh_s;
      ALU_SRL:  res_s = bus.A >> sh_s;
      ALU_SRA:  res_s = WIDTH'($signed(bus.A) >>> sh_s);
      ALU_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      ALU_SLTU: res_s = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      default:  res_s = {WIDTH{1'b0}};
    endcase
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      logic start_s;
      assign start_s = accept_s && is_mul_s;
      alu_mul_seq #(
        .WIDTH(WIDTH)
      ) u_mul (
        .clk  (clk),
        .rst  (rst),
        .start(start_s),
        .a    (bus.A),
        .b    (bus.B),
        .done (mul_done_s),
        .p    (mul_p_s)
      );
    end else begin : g_nomul
      assign mul_done_s = 1'b0;
      assign mul_p_s    = {WIDTH{1'b0}};
    end
  endgenerate

  // Control FSM and output register; a pop and an accept may share an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      out_r       <= {WIDTH{1'b0}};
      flags_r     <= FLAGS_CLR;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            out_valid_r <= 1'b0;
          end
          if (accept_s) begin
            if (is_mul_s) begin
              state_r <= MUL;
              busy_r  <= 1'b1;
            end else begin
              out_r       <= res_s;
              flags_r     <= mk_flags(res_s, carry_s, ov_s);
              out_valid_r <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_done_s) begin
            out_r       <= mul_p_s;
            flags_r     <= mk_flags(mul_p_s, 1'b0, 1'b0);
            out_valid_r <= 1'b1;
            state_r     <= IDLE;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.zeroflag  = flags_r.zero;
  assign bus.negflag   = flags_r.neg;
  assign bus.carryflag = flags_r.carry;
  assign bus.ovflag    = flags_r.ov;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, hand-written multi-cycle
// sequences, and random ops against an arithmetic reference model.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 64;
  localparam logic signed [65:0] MAXS = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] MINS = -MAXS - 66'sd1;

  typedef struct packed {
    logic [63:0] out;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } res_t;

  typedef struct {
    string       name;
    logic [3:0]  m;
    logic [63:0] a;
    logic [63:0] b;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(
    .WIDTH (W),
    .MUL_EN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic res_t mkres(input logic [63:0] o, input logic z, n, c, v);
    res_t r;
    r.out = o; r.z = z; r.n = n; r.c = c; r.v = v;
    return r;
  endfunction

  function automatic vec_t mkvec(input string nm, input logic [3:0] m, input logic [63:0] a, b,
                                 input res_t e);
    vec_t x;
    x.name = nm; x.m = m; x.a = a; x.b = b; x.exp = e;
    return x;
  endfunction

  // Reference: computed from the arithmetic meaning of each opcode.
  function automatic res_t ref_alu(input logic [3:0] m, input logic [63:0] a, b);
    res_t r;
    logic signed [65:0] sa, sb, t;
    logic [63:0] ones;
    int sh;
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    ones = {64{1'b1}};
    sh = int'(b[5:0]);
    r = mkres(64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    case (m)
      4'd0: r.out = a & b;
      4'd1: r.out = a | b;
      4'd2: begin
        r.out = a + b;
        r.c = (r.out < a);
        t = sa + sb;
        r.v = (t > MAXS) || (t < MINS);
      end
      4'd3: begin
        r.out = a - b;
        r.c = (a < b);
        t = sa - sb;
        r.v = (t > MAXS) || (t < MINS);
      end
      4'd4: r.out = b;
      4'd5: r.out = a ^ b;
      4'd6: r.out = a << sh;
      4'd7: r.out = a >> sh;
      4'd8: r.out = (a >> sh) | (a[63] ? ~(ones >> sh) : 64'd0);
      4'd9: r.out = (sa < sb) ? 64'd1 : 64'd0;
      4'd10: r.out = (a < b) ? 64'd1 : 64'd0;
      4'd11: r.out = a * b;
      default: r.out = 64'd0;
    endcase
    r.z = (r.out == 64'd0);
    r.n = r.out[63];
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] m, input logic [63:0] a, b, input res_t e,
                        input string nm);
    int   n;
    logic bad;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    check({nm, " ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.mode = m;
    bus.A = a;
    bus.B = b;
    cyc();
    bus.in_valid = 1'b0;
    bus.mode = ~m;
    bus.A = ~a;
    bus.B = b ^ 64'h5A5A_5A5A_5A5A_5A5A;
    if (m == 4'd11) begin
      n = 1;
      bad = 1'b0;
      while (bus.out_valid !== 1'b1 && n < 200) begin
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
        cyc();
        n++;
      end
      check({nm, " latency"}, 64'(n), 64'd65);
      check({nm, " busy"}, 64'(bad), 64'd0);
    end else begin
      check({nm, " valid"}, 64'(bus.out_valid), 64'd1);
    end
    check({nm, " out"}, bus.out, e.out);
    check({nm, " flags"}, 64'({bus.zeroflag, bus.negflag, bus.carryflag, bus.ovflag}),
          64'({e.z, e.n, e.c, e.v}));
  endtask

  initial begin
    vec_t        tbl[$];
    logic        bad;
    logic        seen;
    logic [3:0]  m;
    logic [63:0] a, b;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.mode = 4'd0;
    bus.A = 64'd0;
    bus.B = 64'd0;
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;

    check("reset out", bus.out, 64'd0);
    check("reset flags", 64'({bus.zeroflag, bus.negflag, bus.carryflag, bus.ovflag}), 64'd0);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd1);

    tbl.push_back(mkvec("add_wrap", 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, mkres(64'd0, 1'b1, 1'b0, 1'b1, 1'b0)));
    tbl.push_back(mkvec("sub_ovf", 4'd3, 64'h8000_0000_0000_0000, 64'd1, mkres(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1)));
    tbl.push_back(mkvec("sub_borrow", 4'd3, 64'd3, 64'd5, mkres(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0)));
    tbl.push_back(mkvec("sra", 4'd8, 64'h8000_0000_0000_0000, 64'd4, mkres(64'hF800_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(mkvec("srl", 4'd7, 64'h8000_0000_0000_0000, 64'd4, mkres(64'h0800_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkvec("slt", 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, mkres(64'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkvec("sltu", 4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, mkres(64'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkvec("and", 4'd0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, mkres(64'hF000_F000_F000_F000, 1'b0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(mkvec("or", 4'd1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, mkres(64'hFFF0_FFF0_FFF0_FFF0, 1'b0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(mkvec("xor", 4'd5, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, mkres(64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkvec("passb", 4'd4, 64'hDEAD, 64'h1234, mkres(64'h1234, 1'b0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkvec("sll_mask", 4'd6, 64'd1, 64'h13F, mkres(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(mkvec("add_ovf", 4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, mkres(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1)));
    tbl.push_back(mkvec("undef", 4'd12, 64'd5, 64'd7, mkres(64'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkvec("add_small", 4'd2, 64'd1, 64'd2, mkres(64'd3, 1'b0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkvec("mul_spec", 4'd11, 64'd12345, 64'd678, mkres(64'd8369910, 1'b0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkvec("mul_neg", 4'd11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, mkres(64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b1, 1'b0, 1'b0)));

    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].name);
    end

    // Back-pressure: result held, no accept, then pop and accept on one edge.
    run_op(4'd2, 64'd10, 64'd20, mkres(64'd30, 1'b0, 1'b0, 1'b0, 1'b0), "bp_first");
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.mode = 4'd5;
    bus.A = 64'hFF;
    bus.B = 64'h0F;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus.out !== 64'd30 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.zeroflag, bus.negflag, bus.carryflag, bus.ovflag} !== 4'b0000) bad = 1'b1;
    end
    check("bp_hold", 64'(bad), 64'd0);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    bus.in_valid = 1'b0;
    check("bp_new_valid", 64'(bus.out_valid), 64'd1);
    check("bp_new_out", bus.out, 64'hF0);
    cyc();
    check("pop_clears_valid", 64'(bus.out_valid), 64'd0);
    check("pop_keeps_out", bus.out, 64'hF0);

    // Reset during a multiply aborts it completely.
    bus.in_valid = 1'b1;
    bus.mode = 4'd11;
    bus.A = 64'd7;
    bus.B = 64'd9;
    cyc();
    bus.in_valid = 1'b0;
    repeat (9) cyc();
    check("mul_busy_mid", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_mul in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_mul busy", 64'(bus.busy), 64'd0);
    check("rst_mul out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mul out", bus.out, 64'd0);
    seen = 1'b0;
    repeat (100) begin
      cyc();
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    check("rst_mul no_valid", 64'(seen), 64'd0);

    // Random ops against the reference model.
    for (int i = 0; i < 250; i++) begin
      m = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        1: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(0, 70)); end
        2: begin a = 64'h8000_0000_0000_0000; b = {$urandom, $urandom}; end
        default: begin a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3)); end
      endcase
      run_op(m, a, b, ref_alu(m, a, b), $sformatf("rand%0d m%0d", i, m));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
